// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_gen_pkg;

    // Transmitter FSM state encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_GAP   = 2'b10
    } state_t;

    // Pattern sent when use_default is set
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

    // Width of a down-counter that must hold the value gap; at least one bit
    // so the counter exists even when back-to-back repetitions are configured.
    function automatic int gap_cnt_w(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// MSB-first parallel-load shift register with a bit-index counter.
// Latency: load/shift take effect on the next clock edge.
// Backpressure: none; the controller decides every cycle whether to load or shift.
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] data,
    output logic         cur_bit,
    output logic         nxt_bit,
    output logic         cur_last,
    output logic         nxt_last
);

    localparam int IDX_W = $clog2(W);

    logic [W-1:0]     sr;
    logic [IDX_W-1:0] idx;

    // Load restarts the word at bit W-1; shift moves the next bit into the MSB
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            sr  <= data;
            idx <= IDX_W'(W - 1);
        end else if (shift) begin
            sr  <= {sr[W-2:0], 1'b0};
            idx <= idx - IDX_W'(1);
        end
    end

    // The controller registers its outputs, so it needs both the bit on the
    // line now and the one that a shift would bring up next.
    assign cur_bit  = sr[W-1];
    assign nxt_bit  = sr[W-2];
    assign cur_last = (idx == '0);
    assign nxt_last = (idx == IDX_W'(1));

endmodule

// File: rtl/seq_gen_1010.sv
// Serial pattern transmitter: sends a W-bit pattern MSB-first, repeated, with optional idle gaps.
// Latency: first bit appears the cycle after an accepted start; done pulses the cycle after the final bit.
// Backpressure: none; start is only honoured in IDLE and abort cancels a run on the next edge.
module seq_gen_1010
    import seq_gen_pkg::*;
#(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = W'(DEFAULT_PATTERN),
    parameter int             CNT_W   = 8,
    parameter int             GAP     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             use_default,
    input  logic [W-1:0]     pattern_in,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_last,
    output logic             busy,
    output logic             done
);

    localparam int GC_W = gap_cnt_w(GAP);

    state_t           state;
    logic [W-1:0]     pat_q;
    logic [CNT_W-1:0] rem;
    logic [GC_W-1:0]  gap_cnt;

    logic             accept;
    logic             more_reps;
    logic             sr_load;
    logic             sr_shift;
    logic [W-1:0]     sr_data;
    logic             sr_cur_bit;
    logic             sr_nxt_bit;
    logic             sr_cur_last;
    logic             sr_nxt_last;

    assign accept    = (state == S_IDLE) && start && !abort;
    assign more_reps = (rem > CNT_W'(1));

    // Shift-register control: load on accept and at each repetition boundary
    // (so the word is ready whether or not a gap follows), shift otherwise.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_data  = pat_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    sr_load = 1'b1;
                    sr_data = use_default ? PATTERN : pattern_in;
                end
            end
            S_SHIFT: begin
                if (!abort) begin
                    if (sr_cur_last) begin
                        sr_load = more_reps;
                    end else begin
                        sr_shift = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    seq_gen_shreg #(
        .W (W)
    ) u_shreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (sr_load),
        .shift    (sr_shift),
        .data     (sr_data),
        .cur_bit  (sr_cur_bit),
        .nxt_bit  (sr_nxt_bit),
        .cur_last (sr_cur_last),
        .nxt_last (sr_nxt_last)
    );

    // FSM with repetition/gap counters; every output is set here for the coming cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            pat_q      <= '0;
            rem        <= '0;
            gap_cnt    <= '0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_SHIFT;
                        pat_q      <= sr_data;
                        rem        <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                        ser_out    <= sr_data[W-1];
                        ser_valid  <= 1'b1;
                        frame_last <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        ser_out    <= 1'b0;
                        ser_valid  <= 1'b0;
                        frame_last <= 1'b0;
                        busy       <= 1'b0;
                    end else if (sr_cur_last) begin
                        if (more_reps) begin
                            rem        <= rem - CNT_W'(1);
                            frame_last <= 1'b0;
                            if (GAP > 0) begin
                                state     <= S_GAP;
                                gap_cnt   <= GC_W'(GAP);
                                ser_out   <= 1'b0;
                                ser_valid <= 1'b0;
                            end else begin
                                ser_out <= pat_q[W-1];
                            end
                        end else begin
                            state      <= S_IDLE;
                            ser_out    <= 1'b0;
                            ser_valid  <= 1'b0;
                            frame_last <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end else begin
                        ser_out    <= sr_nxt_bit;
                        frame_last <= sr_nxt_last;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        ser_out    <= 1'b0;
                        ser_valid  <= 1'b0;
                        frame_last <= 1'b0;
                        busy       <= 1'b0;
                    end else if (gap_cnt == GC_W'(1)) begin
                        // Word was reloaded on entry, so its MSB is already in place
                        state     <= S_SHIFT;
                        ser_out   <= sr_cur_bit;
                        ser_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GC_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_1010.sv
// Scoreboard bench for seq_gen_1010: one instance with a one-cycle gap, one back-to-back.
// Stimulus pushes expected bits/busy lengths/done counts; a negedge monitor pops and compares.
// Inputs are driven 1 time unit after the rising edge.
module tb_seq_gen_1010;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       use_default;
    logic [3:0] pattern_in;
    logic [7:0] repeat_n;

    logic [1:0] so, sv, fl, bz, dn;

    int checks = 0;
    int errors = 0;

    // Index 0: GAP=1 instance, index 1: GAP=0 instance
    logic [1:0] exp_bits [2][$];
    int         exp_busy [2][$];
    int         exp_done [2];
    int         blen [2];
    logic [1:0] pbz;
    logic [1:0] e;

    seq_gen_1010 u_dut (
        .clk (clk), .reset_n (reset_n), .start (start), .abort (abort),
        .use_default (use_default), .pattern_in (pattern_in), .repeat_n (repeat_n),
        .ser_out (so[0]), .ser_valid (sv[0]), .frame_last (fl[0]), .busy (bz[0]), .done (dn[0])
    );

    seq_gen_1010 #(.GAP(0)) u_dut_g0 (
        .clk (clk), .reset_n (reset_n), .start (start), .abort (abort),
        .use_default (use_default), .pattern_in (pattern_in), .repeat_n (repeat_n),
        .ser_out (so[1]), .ser_valid (sv[1]), .frame_last (fl[1]), .busy (bz[1]), .done (dn[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got=%0h exp=%0h", name, i, got, exp);
        end
    endtask

    task automatic fail(input string name, input int i);
        checks++;
        errors++;
        $display("FAIL %s inst%0d unexpected event", name, i);
    endtask

    // Reference: a run is R words of 4 bits with g idle cycles between words,
    // truncated after the cycle in which abort is seen.
    task automatic push_model(input int i, input logic [3:0] pat, input int rep, input int g, input int abort_at);
        int r, len, keep, p;
        r    = (rep == 0) ? 1 : rep;
        len  = 4 * r + g * (r - 1);
        keep = (abort_at >= 0 && abort_at < len) ? abort_at + 1 : len;
        for (int c = 0; c < keep; c++) begin
            p = c % (4 + g);
            if (p < 4) exp_bits[i].push_back({pat[3 - p], logic'(p == 3)});
        end
        exp_busy[i].push_back(keep);
        if (keep == len) exp_done[i]++;
    endtask

    task automatic push_both(input logic [3:0] pat, input int rep, input int abort_at);
        push_model(0, pat, rep, 1, abort_at);
        push_model(1, pat, rep, 0, abort_at);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bz != 2'b00 || dn != 2'b00) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (bz != 2'b00 || dn != 2'b00) fail("idle_timeout", 0);
        @(posedge clk); #1;
    endtask

    // One transaction; inputs are scrambled and start toggled while both are busy
    task automatic run_txn(input logic ud, input logic [3:0] pin, input int rep, input int abort_at);
        int r, lim;
        logic [3:0] pat;
        r   = (rep == 0) ? 1 : rep;
        lim = (abort_at < 0) ? 1000000 : abort_at;
        pat = ud ? 4'b1010 : pin;
        use_default = ud;
        pattern_in  = pin;
        repeat_n    = 8'(rep);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_both(pat, rep, abort_at);
        for (int c = 0; c < 5 * r + 2; c++) begin
            pattern_in  = 4'($urandom);
            use_default = 1'($urandom);
            repeat_n    = 8'($urandom_range(0, 9));
            start       = (c < 4 * r && c <= lim) ? 1'($urandom) : 1'b0;
            abort       = (c == abort_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        wait_idle();
    endtask

    // Monitor: pops expected bits on ser_valid, busy-run lengths on busy fall, done counts on done
    always @(negedge clk) begin
        if (!reset_n) begin
            blen[0] = 0;
            blen[1] = 0;
            pbz     = 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sv[i]) begin
                    if (exp_bits[i].size() == 0) fail("extra_bit", i);
                    else begin
                        e = exp_bits[i].pop_front();
                        chk("bit_last", i, {30'd0, so[i], fl[i]}, {30'd0, e});
                    end
                end else begin
                    chk("idle_out", i, {30'd0, so[i], fl[i]}, 32'd0);
                end
                if (bz[i]) blen[i]++;
                else if (blen[i] != 0) begin
                    if (exp_busy[i].size() == 0) fail("extra_busy", i);
                    else chk("busy_len", i, blen[i], exp_busy[i].pop_front());
                    blen[i] = 0;
                end
                if (dn[i]) begin
                    chk("done_after_busy", i, {30'd0, pbz[i], bz[i]}, 32'd2);
                    if (exp_done[i] == 0) fail("extra_done", i);
                    else exp_done[i]--;
                end
                pbz[i] = bz[i];
            end
        end
    end

    initial begin
        int rep, ab;
        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        use_default = 1'b1;
        pattern_in  = 4'h0;
        repeat_n    = 8'd1;
        exp_done[0] = 0;
        exp_done[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk("reset_state", i, {27'd0, so[i], sv[i], fl[i], bz[i], dn[i]}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Default pattern, single repetition
        run_txn(1'b1, 4'h0, 1, -1);
        // Three repetitions with gaps
        run_txn(1'b1, 4'h0, 3, -1);
        // User pattern, two repetitions
        run_txn(1'b0, 4'b1101, 2, -1);

        // start held through the run; pattern_in/repeat_n changed after acceptance
        use_default = 1'b0;
        pattern_in  = 4'b0110;
        repeat_n    = 8'd2;
        start       = 1'b1;
        @(posedge clk); #1;
        push_both(4'b0110, 2, -1);
        pattern_in = 4'b1001;
        repeat_n   = 8'd1;
        push_both(4'b1001, 1, -1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle();

        // Abort on the third bit of repetition 2 (GAP=1 timing), then a normal run
        run_txn(1'b1, 4'h0, 3, 7);
        run_txn(1'b1, 4'h0, 1, -1);

        // start together with abort in IDLE must be ignored
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) chk("start_abort_idle", i, {30'd0, bz[i], sv[i]}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a run
        use_default = 1'b1;
        repeat_n    = 8'd3;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_both(4'b1010, 3, -1);
        repeat (6) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk("async_reset", i, {27'd0, so[i], sv[i], fl[i], bz[i], dn[i]}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            exp_bits[i].delete();
            exp_busy[i].delete();
            exp_done[i] = 0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) chk("reset_hold", i, {27'd0, so[i], sv[i], fl[i], bz[i], dn[i]}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // repeat_n=0 behaves as a single repetition
        run_txn(1'b1, 4'h0, 0, -1);

        // Randomized runs with occasional aborts
        for (int t = 0; t < 40; t++) begin
            rep = $urandom_range(0, 5);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5 * ((rep == 0) ? 1 : rep) + 1) : -1;
            run_txn(1'($urandom), 4'($urandom), rep, ab);
        end

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("bits_left", i, exp_bits[i].size(), 32'd0);
            chk("busy_left", i, exp_busy[i].size(), 32'd0);
            chk("done_left", i, exp_done[i], 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen_1010.md
Name: seq_gen_1010

Overview:
- Serial pattern transmitter: the generating end of the 1010 sequence-detection path.
- On a start pulse, shifts a W-bit pattern (default 1010) out MSB-first, one bit per clock, for a programmable number of repetitions.
- Optional idle gap between repetitions; completion reported by a done pulse.
- Drives the serial input of the team's Mealy 1010 detector and serves as its stimulus source in system tests.

Parameters:
- W, 4: pattern width in bits (≥2).
- PATTERN, 4'b1010: default pattern, used when use_default=1.
- CNT_W, 8: width of repetition counter.
- GAP, 1: idle cycles inserted between consecutive repetitions (0 = back-to-back).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request a transmission; sampled only in IDLE
- abort  input  1  synchronous cancel; wins over every other event
- use_default  input  1  1 = send PATTERN, 0 = send pattern_in
- pattern_in  input  W  user pattern, captured on accepted start
- repeat_n  input  CNT_W  repetitions, captured on accepted start; 0 treated as 1
- ser_out  output  1  serial data bit
- ser_valid  output  1  ser_out carries a pattern bit this cycle
- frame_last  output  1  current bit is bit 0 of a repetition
- busy  output  1  transmission in progress
- done  output  1  one-cycle pulse after final bit

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n).
- All outputs are registered.
- Reset values: ser_out=0, ser_valid=0, frame_last=0, busy=0, done=0; FSM=IDLE; counters=0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - start=1 at edge k → capture the pattern (PATTERN or pattern_in) into the shift register.
  - Capture rem = (repeat_n==0) ? 1 : repeat_n.
  - Go to SHIFT. After edge k: busy=1, ser_valid=1, ser_out=pattern[W-1].
- SHIFT:
  - Each edge emits the next bit, MSB-first; bit index counts W-1 down to 0.
  - frame_last=1 while bit 0 is presented.
- End of a repetition (edge after bit 0):
  - rem>1 and GAP>0 → GAP. Decrement rem, reload the pattern, hold ser_valid=0 and ser_out=0.
  - rem>1 and GAP=0 → stay in SHIFT with the reloaded pattern; bit W-1 follows immediately.
  - rem==1 → IDLE. busy=0, ser_valid=0, done=1 for exactly one cycle.
- GAP: lasts exactly GAP cycles (gap counter ⌈log2(GAP+1)⌉ bits), then SHIFT with bit W-1.
- Total valid bits = W × max(repeat_n,1); total busy cycles = W×R + GAP×(R−1).
- start while busy: ignored, no effect on the captured pattern or count.
- start on the same edge that done asserts: not accepted, because the FSM is not yet in IDLE. It is accepted the following cycle.
- abort=1 in SHIFT or GAP:
  - Next edge → IDLE; ser_valid=0, busy=0, frame_last=0, done stays 0.
  - A partial repetition is truncated.
  - abort in IDLE is a no-op; abort together with start in IDLE → start ignored.
- pattern_in, use_default and repeat_n changes after acceptance have no effect until the next accepted start.
- reset_n low mid-transmission → immediate return to reset values, no done pulse.
- Widths: the repetition counter saturates at no value; CNT_W bits cover the maximum repeat_n directly.

Decomposition:
- Package seq_gen_pkg:
  - state encoding IDLE=2'b00, SHIFT=2'b01, GAP=2'b10;
  - default pattern constant 4'b1010;
  - helper constant for gap counter width.
- One natural sub-module, seq_gen_shreg: W-bit parallel-load, MSB-first shift register with load/shift enables and bit-index counter providing the last-bit flag.
- FSM and repetition/gap counters stay in the top.

Test Plan:
- Default pattern, repeat_n=1, start pulse at cycle 0 → ser_out 1,0,1,0 with ser_valid=1 on cycles 1–4; frame_last on cycle 4; done=1 on cycle 5 only; busy high cycles 1–4.
- repeat_n=3, GAP=1 → bit stream 1010 _ 1010 _ 1010 with ser_valid=0 in the two gap cycles; 12 valid bits; done once. Looped into the 1010 detector, y pulses 3 times.
- GAP=0, repeat_n=2, use_default=0, pattern_in=4'b1101 → contiguous 11011101; frame_last on bits 4 and 8.
- start held high throughout a repeat_n=2 run → second start accepted only after done, in IDLE; pattern_in changed mid-run is not seen until the second run.
- abort asserted on the 3rd bit of repetition 2 → ser_valid and busy low after the next edge; done never asserts; a new start works normally.
- reset_n pulsed low mid-SHIFT → all outputs 0 immediately (asynchronous). repeat_n=0 after reset → exactly one 4-bit repetition, then done.
